// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the instruction-fetch requester
// (i_*) and the load/store requester (d_*). Only one transaction is in
// flight at a time. Data requests normally win, but fetch is guaranteed a
// grant after STARVE_LIMIT consecutive data grants while it was waiting.
// A watchdog completes a transaction with err=1 if the memory does not
// respond within TIMEOUT cycles of being granted (TIMEOUT=0 disables it).
//
// Ports
//   clk, reset       : clock (rising edge), synchronous active-low reset
//   i_req, i_addr    : fetch request, held stable until i_ack
//   i_ack, i_rdata   : one-cycle fetch completion pulse and its read data
//   d_req, d_we, d_addr, d_wdata, d_be
//                    : load/store request, held stable until d_ack
//   d_ack, d_rdata   : one-cycle data completion pulse, load data (0 for writes)
//   m_req, m_we, m_addr, m_wdata, m_be
//                    : memory request, held until m_gnt
//   m_gnt            : memory accepts when m_req & m_gnt
//   m_rvalid, m_rdata: memory completion and read data
//   err              : pulses with the ack when completion came from timeout
//
// All outputs are registered. FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ack,
   output logic [DW-1:0]   i_rdata,

   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,

   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_be,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [DW-1:0]   m_rdata,

   output logic            err
);

   localparam int BW  = DW / 8;
   // Wait counter only has to reach TIMEOUT-1.
   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST  = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);
   localparam bit             TO_EN      = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t         r_state;
   logic           r_owner_d;      // 1 = current transaction belongs to data port
   logic [3:0]     r_starve_cnt;   // consecutive data grants while fetch waited
   logic [WCW-1:0] r_wait_cnt;     // cycles spent in WAIT

   logic w_any_req;
   logic w_starved;
   logic w_grant_d;
   logic w_timeout;

   assign w_any_req = i_req | d_req;
   assign w_starved = (r_starve_cnt == STARVE_MAX);
   // Data wins unless fetch is also waiting and has hit the starvation bound.
   assign w_grant_d = d_req & ~(i_req & w_starved);
   assign w_timeout = TO_EN && (r_wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_owner_d    <= 1'b0;
         r_starve_cnt <= '0;
         r_wait_cnt   <= '0;
         m_req        <= 1'b0;
         m_we         <= 1'b0;
         m_addr       <= '0;
         m_wdata      <= '0;
         m_be         <= '0;
         i_ack        <= 1'b0;
         d_ack        <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         err          <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_state <= ISSUE;
                  m_req   <= 1'b1;
                  if (w_grant_d) begin
                     r_owner_d <= 1'b1;
                     m_we      <= d_we;
                     m_addr    <= d_addr;
                     m_wdata   <= d_wdata;
                     m_be      <= d_be;
                     // Count only grants that actually made fetch wait.
                     if (i_req) begin
                        if (!w_starved)
                           r_starve_cnt <= r_starve_cnt + 4'd1;
                     end else begin
                        r_starve_cnt <= '0;
                     end
                  end else begin
                     r_owner_d    <= 1'b0;
                     m_we         <= 1'b0;
                     m_addr       <= i_addr;
                     m_wdata      <= '0;
                     m_be         <= {BW{1'b1}};
                     r_starve_cnt <= '0;
                  end
               end
            end

            ISSUE: begin
               if (m_gnt) begin
                  m_req      <= 1'b0;
                  r_wait_cnt <= '0;
                  r_state    <= WAIT;
               end
            end

            WAIT: begin
               if (m_rvalid || w_timeout) begin
                  r_state <= ACK;
                  err     <= ~m_rvalid;
                  if (r_owner_d) begin
                     d_ack   <= 1'b1;
                     // Writes and timed-out reads return zero.
                     d_rdata <= (m_rvalid && !m_we) ? m_rdata : '0;
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= m_rvalid ? m_rdata : '0;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + WCW'(1);
               end
            end

            ACK: begin
               r_state <= IDLE;
               i_ack   <= 1'b0;
               d_ack   <= 1'b0;
               i_rdata <= '0;
               d_rdata <= '0;
               err     <= 1'b0;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT=8). The
// memory side (m_gnt, m_rvalid, m_rdata) is driven directly by each
// scenario task. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, i.e. they show the result of that edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic          clk;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [BW-1:0] d_be;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [BW-1:0] m_be;
   logic          m_gnt;
   logic          m_rvalid;
   logic [DW-1:0] m_rdata;
   logic          err;

   int n_pass;
   int n_total;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      logic [136:0] all_out;
      reset = 1'b0; i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      step(); step();
      all_out = {m_req, m_we, m_addr, m_wdata, m_be, i_ack, d_ack, i_rdata, d_rdata, err};
      n_total++;
      if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
      else n_pass++;

      reset = 1'b1;
      step();
      n_total++;
      if ({m_req, m_we, m_addr, m_be} !== {1'b1, 1'b0, 32'h40, 4'hF})
         $display("FAIL reset_release_issue: m_req=%b m_we=%b m_addr=%h m_be=%h want 1 0 00000040 f",
                  m_req, m_we, m_addr, m_be);
      else n_pass++;

      m_gnt = 1'b1; step();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11; step();
      n_total++;
      if ({i_ack, i_rdata} !== {1'b1, 32'h11})
         $display("FAIL reset_first_ack: i_ack=%b i_rdata=%h want 1 00000011", i_ack, i_rdata);
      else n_pass++;
      $display("txn reset_release fetch addr=00000040 rdata=%h", i_rdata);
      i_req = 1'b0; m_rvalid = 1'b0; step();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_single_fetch();
      i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
      step();
      n_total++;
      if ({m_req, m_addr} !== {1'b1, 32'h100})
         $display("FAIL fetch_issue: m_req=%b m_addr=%h want 1 00000100", m_req, m_addr);
      else n_pass++;
      step();
      n_total++;
      if (m_req !== 1'b0) $display("FAIL fetch_req_drop: m_req=%b want 0", m_req);
      else n_pass++;
      m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
      step();
      n_total++;
      if ({i_ack, i_rdata, d_ack, err} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0})
         $display("FAIL fetch_ack: i_ack=%b i_rdata=%h d_ack=%b err=%b want 1 deadbeef 0 0",
                  i_ack, i_rdata, d_ack, err);
      else n_pass++;
      $display("txn fetch addr=00000100 rdata=%h", i_rdata);
      i_req = 1'b0; m_rvalid = 1'b0; m_gnt = 1'b0;
      step();
      n_total++;
      if ({i_ack, i_rdata} !== '0)
         $display("FAIL fetch_ack_clear: i_ack=%b i_rdata=%h want 0 0", i_ack, i_rdata);
      else n_pass++;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_data_write_stall();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'b0011;
      m_gnt = 1'b0;
      step();
      n_total++;
      if ({m_req, m_we, m_addr, m_wdata, m_be} !== {1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011})
         $display("FAIL write_issue: m_req=%b m_we=%b m_addr=%h m_wdata=%h m_be=%b want 1 1 00000200 12345678 0011",
                  m_req, m_we, m_addr, m_wdata, m_be);
      else n_pass++;
      for (int s = 0; s < 3; s++) begin
         step();
         n_total++;
         if ({m_req, m_we, m_addr, m_wdata, m_be} !== {1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011})
            $display("FAIL write_stall_%0d: m_req=%b m_we=%b m_addr=%h m_wdata=%h m_be=%b want stable request",
                     s, m_req, m_we, m_addr, m_wdata, m_be);
         else n_pass++;
      end
      m_gnt = 1'b1;
      step();
      n_total++;
      if (m_req !== 1'b0) $display("FAIL write_req_drop: m_req=%b want 0", m_req);
      else n_pass++;
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
      step();
      n_total++;
      if ({d_ack, d_rdata, i_ack, err} !== {1'b1, 32'h0, 1'b0, 1'b0})
         $display("FAIL write_ack: d_ack=%b d_rdata=%h i_ack=%b err=%b want 1 00000000 0 0",
                  d_ack, d_rdata, i_ack, err);
      else n_pass++;
      $display("txn data write addr=00000200 rdata=%h", d_rdata);
      d_req = 1'b0; d_we = 1'b0; m_rvalid = 1'b0;
      step();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_starvation();
      // bit k set = grant k expected to go to data: D,D,D,D,I,D,D,D,D,I
      logic [9:0]    order;
      logic          exp_d;
      logic [AW-1:0] exp_addr;
      order = 10'b0111101111;
      i_req = 1'b1; i_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = '0; d_be = 4'hF;
      m_gnt = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_d    = order[k];
         exp_addr = exp_d ? 32'h400 : 32'h300;
         step();
         n_total++;
         if ({m_req, m_addr} !== {1'b1, exp_addr})
            $display("FAIL starve_grant_%0d: m_req=%b m_addr=%h want 1 %h", k, m_req, m_addr, exp_addr);
         else n_pass++;
         step();
         m_rvalid = 1'b1; m_rdata = 32'hA000 + k;
         step();
         n_total++;
         if ({d_ack, i_ack} !== {exp_d, ~exp_d})
            $display("FAIL starve_ack_%0d: d_ack=%b i_ack=%b want %b %b", k, d_ack, i_ack, exp_d, ~exp_d);
         else n_pass++;
         $display("txn grant %0d to %s", k, d_ack ? "data" : (i_ack ? "fetch" : "none"));
         m_rvalid = 1'b0;
         if (k == 9) begin
            i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
         end
         step();
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_timeout();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; m_gnt = 1'b1; m_rvalid = 1'b0;
      step();      // IDLE -> ISSUE
      step();      // granted, now in WAIT
      for (int s = 0; s < 7; s++) begin
         step();
         n_total++;
         if ({d_ack, err} !== 2'b00)
            $display("FAIL timeout_early_%0d: d_ack=%b err=%b want 0 0", s, d_ack, err);
         else n_pass++;
      end
      step();
      n_total++;
      if ({d_ack, err, d_rdata, i_ack} !== {1'b1, 1'b1, 32'h0, 1'b0})
         $display("FAIL timeout_ack: d_ack=%b err=%b d_rdata=%h i_ack=%b want 1 1 00000000 0",
                  d_ack, err, d_rdata, i_ack);
      else n_pass++;
      $display("txn data read addr=00000500 timed out err=%b", err);
      d_req = 1'b0;
      step();
      n_total++;
      if ({d_ack, err} !== 2'b00) $display("FAIL timeout_clear: d_ack=%b err=%b want 0 0", d_ack, err);
      else n_pass++;

      d_req = 1'b1; d_addr = 32'h504;
      step();
      n_total++;
      if ({m_req, m_addr} !== {1'b1, 32'h504})
         $display("FAIL after_timeout_issue: m_req=%b m_addr=%h want 1 00000504", m_req, m_addr);
      else n_pass++;
      step();
      m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
      step();
      n_total++;
      if ({d_ack, d_rdata, err} !== {1'b1, 32'hCAFEF00D, 1'b0})
         $display("FAIL after_timeout_ack: d_ack=%b d_rdata=%h err=%b want 1 cafef00d 0", d_ack, d_rdata, err);
      else n_pass++;
      $display("txn data read addr=00000504 rdata=%h", d_rdata);
      d_req = 1'b0; m_rvalid = 1'b0; m_gnt = 1'b0;
      step();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset_mid();
      logic [136:0] all_out;
      i_req = 1'b1; i_addr = 32'h600; m_gnt = 1'b1;
      step();      // ISSUE
      step();      // WAIT
      reset = 1'b0; m_gnt = 1'b0;
      step();
      all_out = {m_req, m_we, m_addr, m_wdata, m_be, i_ack, d_ack, i_rdata, d_rdata, err};
      n_total++;
      if (all_out !== '0) $display("FAIL reset_mid_outputs: got %h want 0", all_out);
      else n_pass++;
      reset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0BAD0BAD;
      step();
      n_total++;
      if ({i_ack, d_ack, err, m_req, m_addr} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'h600})
         $display("FAIL reset_mid_reissue: i_ack=%b d_ack=%b err=%b m_req=%b m_addr=%h want 0 0 0 1 00000600",
                  i_ack, d_ack, err, m_req, m_addr);
      else n_pass++;
      m_rvalid = 1'b0; m_gnt = 1'b1;
      step();
      n_total++;
      if ({i_ack, m_req} !== 2'b00)
         $display("FAIL reset_mid_stray: i_ack=%b m_req=%b want 0 0", i_ack, m_req);
      else n_pass++;
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77;
      step();
      n_total++;
      if ({i_ack, i_rdata, err} !== {1'b1, 32'h77, 1'b0})
         $display("FAIL reset_mid_ack: i_ack=%b i_rdata=%h err=%b want 1 00000077 0", i_ack, i_rdata, err);
      else n_pass++;
      $display("txn fetch reissue addr=00000600 rdata=%h", i_rdata);
      i_req = 1'b0; m_rvalid = 1'b0;
      step();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_single_fetch();
      test_data_write_stall();
      test_starvation();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
